riscv_str_dec_mc: RTL and testbench

- Multi-cycle, byte-serial string *decode* unit in the EX stage.
- Inverse counterpart of the single-cycle string-ops encoder:
  - lowercase is the inverse of uppercase;
  - un-leet is the inverse of leet speak;
  - ROT13 is self-inverse.
- Accepts one 32-bit word from ID/EX with a valid/ready handshake.
- Processes one byte per cycle, LSB first.
- Presents the result with a valid/ready handshake toward writeback.

---
 rtl/riscv_str_dec_mc.sv | 132 +++++++++++++
 tb/tb_riscv_str_dec_mc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_str_dec_mc.sv
// riscv_str_dec_mc: multi-cycle byte-serial string decode unit (EX stage).
// Decodes one 32-bit word, one byte per cycle LSB first, with valid/ready
// handshakes on both the request and result sides.
// Optional build macro: RISCV_STR_DEC_NUL_TERM_EN (stop at the first 0x00 byte).
module riscv_str_dec_mc #(
    parameter int unsigned                STR_OP_WIDTH = 2,
    parameter logic [STR_OP_WIDTH-1:0]    OP_LOWER     = 2'd1,
    parameter logic [STR_OP_WIDTH-1:0]    OP_UNLEET    = 2'd2,
    parameter logic [STR_OP_WIDTH-1:0]    OP_ROT13     = 2'd3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [31:0]             result_o,
    input  logic                    ready_i
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [STR_OP_WIDTH-1:0] op_q, op_d;
    logic [31:0]             operand_q, operand_d;
    logic [31:0]             res_q, res_d;
    logic [7:0]              src_byte;

    // Single-byte decode; unmatched bytes and unknown opcodes pass through.
    function automatic logic [7:0] xform(input logic [7:0] b,
                                         input logic [STR_OP_WIDTH-1:0] op);
        logic [7:0] r;
        r = b;
        case (op)
            OP_LOWER: begin
                if (b >= 8'h41 && b <= 8'h5A) r = b + 8'h20;
            end
            OP_UNLEET: begin
                case (b)
                    8'h34:   r = 8'h61; // '4' -> 'a'
                    8'h33:   r = 8'h65; // '3' -> 'e'
                    8'h31:   r = 8'h69; // '1' -> 'i'
                    8'h30:   r = 8'h6F; // '0' -> 'o'
                    8'h35:   r = 8'h73; // '5' -> 's'
                    8'h37:   r = 8'h74; // '7' -> 't'
                    default: r = b;
                endcase
            end
            OP_ROT13: begin
                // Add 13 in the first half of each alphabet, subtract in the second.
                if ((b >= 8'h41 && b <= 8'h4D) || (b >= 8'h61 && b <= 8'h6D)) begin
                    r = b + 8'd13;
                end else if ((b >= 8'h4E && b <= 8'h5A) || (b >= 8'h6E && b <= 8'h7A)) begin
                    r = b - 8'd13;
                end
            end
            default: r = b;
        endcase
        return r;
    endfunction

    assign src_byte = operand_q[{idx_q, 3'b000} +: 8];

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            op_q      <= '0;
            operand_q <= 32'd0;
            res_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            res_q     <= res_d;
        end
    end

    // Next-state: accept in idle, one byte per busy cycle, hold in done.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        operand_d = operand_q;
        res_d     = res_q;
        case (state_q)
            StIdle: begin
                if (enable_i) begin
                    op_d      = operator_i;
                    operand_d = operand_i;
                    res_d     = 32'd0;
                    idx_d     = 2'd0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                res_d[{idx_q, 3'b000} +: 8] = xform(src_byte, op_q);
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    idx_d   = 2'd0;
                    state_d = StDone;
                end
`ifdef RISCV_STR_DEC_NUL_TERM_EN
                // Terminator found: blank this byte and everything above it.
                if (src_byte == 8'h00) begin
                    for (int i = 0; i < 4; i++) begin
                        if (2'(i) >= idx_q) res_d[8*i +: 8] = 8'h00;
                    end
                    idx_d   = 2'd0;
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                if (ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; result is masked to zero unless valid.
    always_comb begin
        ready_o  = (state_q == StIdle);
        valid_o  = (state_q == StDone);
        result_o = (state_q == StDone) ? res_q : 32'd0;
    end

endmodule

// File: tb/tb_riscv_str_dec_mc.sv
// Directed self-checking bench for riscv_str_dec_mc with a result scoreboard.
module tb_riscv_str_dec_mc;

    logic        clk;
    logic        rst;
    logic        enable_i;
    logic [1:0]  operator_i;
    logic [31:0] operand_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        ready_i;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] sb[$];

    riscv_str_dec_mc dut (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (enable_i),
        .operator_i (operator_i),
        .operand_i  (operand_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .ready_i    (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge while idle; returns just after the negedge following accept.
    task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [31:0] exp);
        check("ready_before_accept", {31'd0, ready_o}, 32'd1);
        enable_i   = 1'b1;
        operator_i = op;
        operand_i  = data;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        enable_i   = 1'b0;
        operator_i = 2'd0;
        operand_i  = 32'hDEAD_BEEF;
        check("ready_falls", {31'd0, ready_o}, 32'd0);
        check("valid_low_busy", {31'd0, valid_o}, 32'd0);
    endtask

    // Count edges after accept until valid_o, then compare against the scoreboard.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        logic [31:0] exp;
        lat = 1;
        while (!valid_o && lat < 16) begin
            @(negedge clk);
            if (!valid_o) lat++;
        end
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            check({tag, "_result"}, result_o, exp);
        end
    endtask

    task automatic release_result(input string tag);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check({tag, "_valid_clr"}, {31'd0, valid_o}, 32'd0);
        check({tag, "_result_clr"}, result_o, 32'd0);
        check({tag, "_ready_back"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        enable_i   = 1'b0;
        operator_i = 2'd0;
        operand_i  = 32'd0;
        ready_i    = 1'b0;
        #12;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // LOWER "HELL"
        issue(2'd1, 32'h4C4C4548, 32'h6C6C6568);
        wait_result("lower_hell", 4);
        release_result("lower_hell");

        // UNLEET "3457" -> "east"
        issue(2'd2, 32'h37353433, 32'h74736165);
        wait_result("unleet_east", 4);
        release_result("unleet_east");

        // UNLEET mixed with non-leet bytes
        issue(2'd2, 32'h30314142, 32'h6F694142);
        wait_result("unleet_mix", 4);
        release_result("unleet_mix");

        // Opcode 0 pass-through
        issue(2'd0, 32'h37353433, 32'h37353433);
        wait_result("op0_pass", 4);
        release_result("op0_pass");

        // ROT13 boundaries
        issue(2'd3, 32'h7A6E4161, 32'h6D614E6E);
        wait_result("rot13_za", 4);
        release_result("rot13_za");
        issue(2'd3, 32'h5B7B405A, 32'h5B7B404D);
        wait_result("rot13_edge", 4);
        release_result("rot13_edge");

        // Backpressure: hold DONE three cycles, enable_i pulsed and ignored
        issue(2'd1, 32'h41414141, 32'h61616161);
        wait_result("bp", 4);
        for (int i = 0; i < 3; i++) begin
            enable_i   = (i == 1);
            operator_i = 2'd3;
            operand_i  = 32'h11111111;
            @(negedge clk);
            check("bp_hold_valid", {31'd0, valid_o}, 32'd1);
            check("bp_hold_result", result_o, 32'h61616161);
            check("bp_hold_ready", {31'd0, ready_o}, 32'd0);
        end
        // Simultaneous ready_i and enable_i: consumed, request not taken
        enable_i = 1'b1;
        ready_i  = 1'b1;
        @(negedge clk);
        enable_i = 1'b0;
        ready_i  = 1'b0;
        check("bp_consume_valid", {31'd0, valid_o}, 32'd0);
        check("bp_no_accept", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        check("bp_still_idle", {31'd0, ready_o}, 32'd1);
        issue(2'd3, 32'h61616161, 32'h6E6E6E6E);
        wait_result("bp_next", 4);
        release_result("bp_next");

        // Reset during the third BUSY cycle discards the partial result
        issue(2'd3, 32'h61616161, 32'h6E6E6E6E);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);
        check("midrst_ready", {31'd0, ready_o}, 32'd1);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_valid", {31'd0, valid_o}, 32'd0);
        @(negedge clk);
        issue(2'd3, 32'h6E6E6E6E, 32'h61616161);
        wait_result("after_rst", 4);
        release_result("after_rst");

        // NUL byte handling
`ifdef RISCV_STR_DEC_NUL_TERM_EN
        issue(2'd1, 32'h41004142, 32'h00006162);
        wait_result("nul", 3);
`else
        issue(2'd1, 32'h41004142, 32'h61006162);
        wait_result("nul", 4);
`endif
        release_result("nul");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
